// File: rtl/ty_stream_frame_ctrl_pkg.sv
// Shared types and constants for the TyBEC stream-frame controller.
package ty_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int unsigned TY_WORD_W   = 32;
  localparam int unsigned TY_PIPE_LAT = 6;

  // Per-lane byte count to beat count; sub-word remainder is dropped.
  function automatic logic [31:0] bytes_to_beats(input logic [31:0] bytes,
                                                 input int unsigned word_w);
    logic [31:0] r;
    r = bytes;
    for (int unsigned w = 8; w < word_w; w = w * 2) r = r >> 1;
    return r;
  endfunction

endpackage

// File: rtl/ty_stream_frame_ctrl_if.sv
// Shell-side, kernel-side and output stream handshakes of the frame controller.
interface ty_stream_frame_ctrl_if
  import ty_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 4 * TY_WORD_W
);
  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic              k_ivalid;
  logic              k_iready;
  logic [DATA_W-1:0] k_idata;
  logic              k_ovalid;
  logic              k_oready;
  logic [DATA_W-1:0] k_odata;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;

  modport master (
    input  s_tvalid, s_tdata, k_iready, k_ovalid, k_odata, m_tready,
    output s_tready, k_ivalid, k_idata, k_oready, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    output s_tvalid, s_tdata, k_iready, k_ovalid, k_odata, m_tready,
    input  s_tready, k_ivalid, k_idata, k_oready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/ty_stream_frame_ctrl_beat_counter.sv
// Clearable, non-wrapping beat counter with an equality compare against a terminal value.
module ty_beat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_term
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge aclk) begin
    if (areset || i_clr) r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt     = r_cnt;
  assign o_at_term = (r_cnt == i_term);
endmodule

// File: rtl/ty_stream_frame_ctrl.sv
// Frame controller between the AXI-stream shell and a TyBEC kernel: counts beats,
// flushes the kernel pipeline and marks the last output. Optional: TY_FRAME_PERF_EN.
module ty_stream_frame_ctrl
  import ty_stream_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WORD_W   = TY_WORD_W,
  parameter int unsigned PIPE_LAT = TY_PIPE_LAT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [31:0]          ctrl_xfer_size_in_bytes,
  ty_stream_frame_ctrl_if.master bus,
  output logic                 busy,
  output logic                 done
`ifdef TY_FRAME_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_in_stall,
  output logic [31:0]          perf_out_stall
`endif
);
  localparam int unsigned DW = NUM_CH * WORD_W;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_beats;
  logic [CNT_W-1:0] w_beats, w_term;
  logic [31:0]      w_beats_full;
  logic [CNT_W-1:0] w_in_cnt, w_out_cnt, w_flush_cnt;
  logic             w_in_at_term, w_out_at_term, w_flush_at_term;
  logic             w_clr, w_in_hs, w_out_hs, w_flush_hs, w_out_open;
  logic             w_s_tready, w_k_ivalid, w_k_oready, w_m_tvalid, w_m_tlast;
  logic [DW-1:0]    w_k_idata;
  logic             w_unused;

  assign w_beats_full = bytes_to_beats(ctrl_xfer_size_in_bytes, WORD_W);

  // Frame length saturates when the counters are narrower than the size field.
  generate
    if (CNT_W >= 32) begin : g_wide
      assign w_beats = CNT_W'(w_beats_full);
    end else begin : g_narrow
      assign w_beats = (|(w_beats_full >> CNT_W)) ? '1 : w_beats_full[CNT_W-1:0];
    end
  endgenerate

  assign w_term     = r_beats - CNT_W'(1);
  assign w_clr      = (r_state == IDLE) && start;
  assign w_in_hs    = (r_state == RUN) && bus.s_tvalid && bus.k_iready;
  assign w_out_hs   = busy && w_m_tvalid && bus.m_tready;
  assign w_flush_hs = (r_state == DRAIN) && w_k_ivalid && bus.k_iready;
  assign w_out_open = (w_out_cnt < r_beats);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_beats <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr) r_beats <= w_beats;
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    w_s_tready = 1'b0;
    w_k_ivalid = 1'b0;
    w_k_idata  = '0;
    w_k_oready = 1'b1;
    w_m_tvalid = 1'b0;
    w_m_tlast  = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next = (w_beats == '0) ? DONE : RUN;
      RUN: begin
        busy       = 1'b1;
        w_k_ivalid = bus.s_tvalid;
        w_s_tready = bus.k_iready;
        w_k_idata  = bus.s_tdata;
        if (w_in_hs && w_in_at_term) w_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        w_k_ivalid = (w_flush_cnt < CNT_W'(PIPE_LAT));
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (busy) begin
      w_m_tvalid = bus.k_ovalid && w_out_open;
      w_k_oready = bus.m_tready || !w_out_open;
      w_m_tlast  = w_m_tvalid && w_out_at_term;
      // Completion overrides the RUN->DRAIN step and abandons any pending flush.
      if (w_m_tvalid && bus.m_tready && w_out_at_term) w_next = DONE;
    end
  end

  ty_beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .aclk(aclk), .areset(areset), .i_clr(w_clr), .i_inc(w_in_hs),
    .i_term(w_term), .o_cnt(w_in_cnt), .o_at_term(w_in_at_term)
  );

  ty_beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
    .aclk(aclk), .areset(areset), .i_clr(w_clr), .i_inc(w_out_hs),
    .i_term(w_term), .o_cnt(w_out_cnt), .o_at_term(w_out_at_term)
  );

  ty_beat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .aclk(aclk), .areset(areset), .i_clr(w_clr), .i_inc(w_flush_hs),
    .i_term(CNT_W'(PIPE_LAT)), .o_cnt(w_flush_cnt), .o_at_term(w_flush_at_term)
  );

  assign w_unused = ^{w_in_cnt, w_flush_at_term};

  assign bus.s_tready = w_s_tready;
  assign bus.k_ivalid = w_k_ivalid;
  assign bus.k_idata  = w_k_idata;
  assign bus.k_oready = w_k_oready;
  assign bus.m_tvalid = w_m_tvalid;
  assign bus.m_tdata  = bus.k_odata;
  assign bus.m_tlast  = w_m_tlast;

`ifdef TY_FRAME_PERF_EN
  logic [31:0] r_perf_cycles, r_perf_in_stall, r_perf_out_stall;

  always_ff @(posedge aclk) begin
    if (areset || w_clr) begin
      r_perf_cycles    <= '0;
      r_perf_in_stall  <= '0;
      r_perf_out_stall <= '0;
    end else begin
      if (busy && (r_perf_cycles != '1))
        r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == RUN) && bus.s_tvalid && !bus.k_iready && (r_perf_in_stall != '1))
        r_perf_in_stall <= r_perf_in_stall + 32'd1;
      if (w_m_tvalid && !bus.m_tready && (r_perf_out_stall != '1))
        r_perf_out_stall <= r_perf_out_stall + 32'd1;
    end
  end

  assign perf_cycles    = r_perf_cycles;
  assign perf_in_stall  = r_perf_in_stall;
  assign perf_out_stall = r_perf_out_stall;
`endif
endmodule

// File: tb/tb_ty_stream_frame_ctrl.sv
// Directed bench for ty_stream_frame_ctrl with a 6-stage stallable kernel model.
module tb_ty_stream_frame_ctrl;
  localparam int unsigned DW = 128;
  localparam logic [DW-1:0] KMASK = {4{32'hA5A5_5A5A}};

  logic        aclk = 1'b0;
  logic        areset, start, busy, done, kr_en;
  logic [31:0] size;
  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
`ifdef TY_FRAME_PERF_EN
  logic [31:0] perf_cycles, perf_in_stall, perf_out_stall;
`endif

  ty_stream_frame_ctrl_if #(.DATA_W(DW)) sif ();

  ty_stream_frame_ctrl #(.NUM_CH(4), .WORD_W(32), .PIPE_LAT(6), .CNT_W(32)) dut (
    .aclk(aclk), .areset(areset), .start(start), .ctrl_xfer_size_in_bytes(size),
    .bus(sif), .busy(busy), .done(done)
`ifdef TY_FRAME_PERF_EN
    , .perf_cycles(perf_cycles), .perf_in_stall(perf_in_stall), .perf_out_stall(perf_out_stall)
`endif
  );

  always #5 aclk = ~aclk;

  // Kernel model: whole pipe freezes while k_oready is low.
  logic          kv [6];
  logic [DW-1:0] kd [6];
  always @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < 6; i++) kv[i] <= 1'b0;
    end else if (sif.k_oready) begin
      kv[0] <= sif.k_ivalid && sif.k_iready;
      kd[0] <= sif.k_idata ^ KMASK;
      for (int i = 1; i < 6; i++) begin
        kv[i] <= kv[i-1];
        kd[i] <= kd[i-1];
      end
    end
  end
  assign sif.k_ovalid = kv[5];
  assign sif.k_odata  = kd[5];
  assign sif.k_iready = kr_en && sif.k_oready;

  function automatic logic [DW-1:0] in_word(input int unsigned i);
    logic [DW-1:0] w;
    for (int l = 0; l < 4; l++) w[DW-1-32*l -: 32] = 32'h0100_0000 * (l + 1) + 32'(i);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0 ideal, 1 valid/ready toggling, 2 output backpressure, 3 reset abort, 4 k_iready stalls
  task automatic run_frame(input logic [31:0] nbytes, input int mode);
    int unsigned beats;
    int unsigned idx, out_idx, nflush, ndone, nbusy, cyc;
    logic prev_final, prev_stall, fin, aborted;
    logic [DW-1:0] prev_data;
    beats = nbytes >> 2;
    idx = 0; out_idx = 0; nflush = 0; ndone = 0; nbusy = 0; cyc = 0;
    prev_final = (beats == 0); prev_stall = 1'b0; fin = 1'b0; aborted = 1'b0;
    prev_data = '0;
    @(posedge aclk); #1;
    start = 1'b1; size = nbytes;
    while (!fin && !aborted && cyc < 2000) begin
      @(posedge aclk); #1;
      start = 1'b0;
      sif.s_tvalid = (idx < beats) && (mode != 1 || cyc % 2 == 0);
      sif.s_tdata  = in_word(idx);
      kr_en = !((mode == 1 && cyc % 3 == 2) ||
                (mode == 4 && (cyc == 2 || cyc == 5 || cyc == 8 || cyc == 11)));
      sif.m_tready = !(mode == 2 && cyc >= 8 && cyc < 28);
      @(negedge aclk);
      if (beats == 0) begin
        chk("zero_s_tready", sif.s_tready, 0);
        chk("zero_m_tvalid", sif.m_tvalid, 0);
      end
      if (prev_stall) begin
        chk("hold_valid", sif.m_tvalid, 1);
        chk("hold_data", sif.m_tdata, prev_data);
      end
      prev_stall = sif.m_tvalid && !sif.m_tready;
      prev_data  = sif.m_tdata;
      if (busy) nbusy++;
      if (sif.k_ivalid && sif.k_iready && !sif.s_tready) begin
        chk("flush_data", sif.k_idata, 0);
        nflush++;
      end
      if (done) begin
        chk("done_timing", prev_final, 1);
        ndone++;
        fin = 1'b1;
      end
      prev_final = 1'b0;
      if (sif.m_tvalid && sif.m_tready) begin
        chk("out_data", sif.m_tdata, in_word(out_idx) ^ KMASK);
        chk("out_last", sif.m_tlast, (out_idx == beats - 1));
        prev_final = sif.m_tlast;
        out_idx++;
      end
      if (sif.s_tvalid && sif.s_tready) idx++;
      cyc++;
      if (mode == 3 && idx == 8) aborted = 1'b1;
    end
    if (aborted) begin
      @(posedge aclk); #1;
      areset = 1'b1; sif.s_tvalid = 1'b0;
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_k_oready", sif.k_oready, 1);
      chk("abort_in_cnt", dut.w_in_cnt, 0);
      chk("abort_out_cnt", dut.w_out_cnt, 0);
      chk("abort_flush_cnt", dut.w_flush_cnt, 0);
      chk("abort_no_done", ndone, 0);
    end else begin
      chk("frame_done_seen", fin, 1);
      chk("in_beats", idx, beats);
      chk("out_beats", out_idx, beats);
      chk("done_count", ndone, 1);
      if (mode == 0 && beats > 0) chk("flush_beats", nflush, 6);
`ifdef TY_FRAME_PERF_EN
      chk("perf_cycles", perf_cycles, nbusy);
      if (mode == 4) chk("perf_in_stall", perf_in_stall, 4);
      chk("perf_out_stall", perf_out_stall, (mode == 2) ? 20 : 0);
`endif
      @(negedge aclk);
      chk("done_single", done, 0);
      chk("idle_busy", busy, 0);
`ifdef TY_FRAME_PERF_EN
      chk("perf_hold", perf_cycles, nbusy);
`endif
    end
    sif.s_tvalid = 1'b0;
    kr_en = 1'b1;
    sif.m_tready = 1'b1;
    repeat (20) @(posedge aclk);
    #1;
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; size = '0; kr_en = 1'b1;
    sif.s_tvalid = 1'b0; sif.s_tdata = '0; sif.m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_tready", sif.s_tready, 0);
    chk("rst_k_ivalid", sif.k_ivalid, 0);
    chk("rst_m_tvalid", sif.m_tvalid, 0);
    chk("rst_m_tlast", sif.m_tlast, 0);
    chk("rst_k_oready", sif.k_oready, 1);
    chk("rst_out_cnt", dut.w_out_cnt, 0);

    run_frame(32'd64, 0);
    run_frame(32'd64, 1);
    run_frame(32'd64, 2);
    run_frame(32'd0, 0);
    run_frame(32'd3, 0);
    run_frame(32'd64, 3);
    run_frame(32'd32, 0);
    run_frame(32'd64, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
